// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier for the EX-stage multiply handshake.
// Retires STEP multiplier bits per cycle on operand magnitudes, then applies the sign in the last step.
//
// state | meaning
// IDLE  | waiting for mult_start_i; operands are captured when it is seen
// CALC  | accumulating partial products, cnt_q counts down to 0
// DONE  | product_o valid, mult_end_o high until mult_ack_i
module iter_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 mult_start_i,
  input  logic                 mult_signed_i,
  input  logic [WIDTH-1:0]     mult_opd1_i,
  input  logic [WIDTH-1:0]     mult_opd2_i,
  input  logic                 mult_ack_i,
  input  logic                 flush_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 mult_end_o,
  output logic                 busy_o
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     mag1, mag2;
  logic                 neg_q, neg_d;
  logic                 capture;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Flush beats everything, including start and ack.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (mult_start_i) state_d = S_CALC;
        S_CALC:  if (cnt_q == '0) state_d = S_DONE;
        S_DONE:  if (mult_ack_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mult_end_o = (state_q == S_DONE);
    busy_o     = (state_q != S_IDLE);
  end

  assign product_o = product_q;
  assign capture   = (state_q == S_IDLE) && mult_start_i && !flush_i;

  // Negating the most negative value gives 2^(WIDTH-1), which is exact as unsigned.
  always_comb begin
    mag1 = (mult_signed_i && mult_opd1_i[WIDTH-1]) ? -mult_opd1_i : mult_opd1_i;
    mag2 = (mult_signed_i && mult_opd2_i[WIDTH-1]) ? -mult_opd2_i : mult_opd2_i;
  end

  always_comb begin
    acc_sum = acc_q;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_q[i]) acc_sum = acc_sum + (mcand_q << i);
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (capture) begin
      mcand_d  = {{WIDTH{1'b0}}, mag1};
      mplier_d = mag2;
      acc_d    = '0;
      neg_d    = mult_signed_i && (mult_opd1_i[WIDTH-1] ^ mult_opd2_i[WIDTH-1]);
      cnt_d    = CNT_INIT;
    end else if (state_q == S_CALC && !flush_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << STEP;
      mplier_d = mplier_q >> STEP;
      if (cnt_q == '0) begin
        product_d = neg_q ? -acc_sum : acc_sum;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed bench for iter_multiplier: products, latency, DONE hold, ack/start overlap, flush and async reset.
module tb_iter_multiplier;

  localparam int WIDTH = 32;
  localparam int N     = 16;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b0;
  logic               mult_start_i = 1'b0;
  logic               mult_signed_i = 1'b0;
  logic [WIDTH-1:0]   mult_opd1_i = '0;
  logic [WIDTH-1:0]   mult_opd2_i = '0;
  logic               mult_ack_i = 1'b0;
  logic               flush_i = 1'b0;
  logic [2*WIDTH-1:0] product_o;
  logic               mult_end_o;
  logic               busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  iter_multiplier #(.WIDTH(WIDTH), .STEP(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .mult_start_i  (mult_start_i),
    .mult_signed_i (mult_signed_i),
    .mult_opd1_i   (mult_opd1_i),
    .mult_opd2_i   (mult_opd2_i),
    .mult_ack_i    (mult_ack_i),
    .flush_i       (flush_i),
    .product_o     (product_o),
    .mult_end_o    (mult_end_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Start is captured at the edge inside this task; operands are then scrambled.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    mult_signed_i = sgn;
    mult_opd1_i   = a;
    mult_opd2_i   = b;
    mult_start_i  = 1'b1;
    step();
    mult_start_i  = 1'b0;
    mult_opd1_i   = 32'hDEAD_BEEF;
    mult_opd2_i   = 32'h1234_5678;
    mult_signed_i = ~sgn;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!mult_end_o && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  task automatic ack_op();
    mult_ack_i = 1'b1;
    step();
    mult_ack_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int c;
    start_op(sgn, a, b);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    wait_done(c);
    check({tag, "_lat"}, 64'(c), 64'(N));
    check({tag, "_prod"}, product_o, exp);
    ack_op();
    check({tag, "_end_after_ack"}, 64'(mult_end_o), 64'd0);
  endtask

  initial begin
    int c;
    int seen;
    logic [63:0] held;

    #3;
    check("rst_prod", product_o, 64'd0);
    check("rst_end", 64'(mult_end_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    #4 rst_n_i = 1'b1;
    step();

    run_op("u3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op("sm7x6", 1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("s_m1_sq", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    run_op("s_5x0", 1'b1, 32'd5, 32'd0, 64'd0);
    run_op("s_min_x1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

    // DONE hold with ack low, then ack while start is still high.
    start_op(1'b0, 32'd1000, 32'd1000);
    wait_done(c);
    check("hold_lat", 64'(c), 64'(N));
    held = product_o;
    check("hold_prod0", held, 64'd1_000_000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_end", 64'(mult_end_o), 64'd1);
      check("hold_prod", product_o, held);
    end
    mult_start_i = 1'b1;
    mult_signed_i = 1'b0;
    mult_opd1_i = 32'd1000;
    mult_opd2_i = 32'd1000;
    mult_ack_i = 1'b1;
    step();
    mult_ack_i = 1'b0;
    check("ack_no_recapture_busy", 64'(busy_o), 64'd0);
    check("ack_end_low", 64'(mult_end_o), 64'd0);
    mult_opd1_i = 32'd2;
    mult_opd2_i = 32'd2;
    step();
    mult_start_i = 1'b0;
    check("second_busy", 64'(busy_o), 64'd1);
    wait_done(c);
    check("second_lat", 64'(c), 64'(N));
    check("second_prod", product_o, 64'd4);
    ack_op();

    // Flush in the middle of CALC.
    start_op(1'b0, 32'd7, 32'd3);
    for (int i = 0; i < 6; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_end", 64'(mult_end_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mult_end_o || busy_o) seen++;
    end
    check("flush_quiet", 64'(seen), 64'd0);
    run_op("after_flush_9x9", 1'b0, 32'd9, 32'd9, 64'd81);

    // Asynchronous reset between edges mid-CALC.
    start_op(1'b0, 32'd12, 32'd12);
    for (int i = 0; i < 5; i++) step();
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_prod", product_o, 64'd0);
    check("arst_end", 64'(mult_end_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    #1 rst_n_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mult_end_o || busy_o) seen++;
    end
    check("arst_quiet", 64'(seen), 64'd0);
    run_op("after_rst_6x7", 1'b0, 32'd6, 32'd7, 64'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
